// File: rtl/switch_toggle_decoder.sv
// switch_toggle_decoder
// Synchronises, debounces and release-decodes the two board push-switches.
// One toggle bit per switch; LED_1/LED_2 show XOR/XNOR of the toggle bits.
// Optional feature macro: SWITCH_PRESS_COUNT_EN adds a 2-bit release counter
// on LED_3/LED_4. Without it, those LEDs are tied low.
//
// Per-switch debounce state, implied by the counter value:
//   state    | meaning
//   STABLE   | counter == 0, synced level matches the accepted level
//   COUNTING | counter != 0, synced level differs, waiting for DEBOUNCE_LIMIT
module switch_toggle_decoder #(
    parameter int DEBOUNCE_LIMIT = 250000
) (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_Switch_1,
    input  logic i_Switch_2,
    output logic o_Debounced_1,
    output logic o_Debounced_2,
    output logic o_LED_1,
    output logic o_LED_2,
    output logic o_LED_3,
    output logic o_LED_4
);

    localparam int CNT_W = $clog2(DEBOUNCE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

    logic [1:0]       raw_sw;
    logic [1:0]       sync_meta;
    logic [1:0]       sync_q;
    logic [1:0]       stable;
    logic [1:0]       stable_d;
    logic [1:0]       release_p;
    logic [1:0]       toggle;
    logic [CNT_W-1:0] db_cnt [2];

    assign raw_sw = {i_Switch_2, i_Switch_1};

    // Two-flop synchroniser for both asynchronous switch pins.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            sync_meta <= '0;
            sync_q    <= '0;
        end else begin
            sync_meta <= raw_sw;
            sync_q    <= sync_meta;
        end
    end

    // Debounce: accept a new level only after it persists DEBOUNCE_LIMIT cycles;
    // any return to the accepted level restarts the count.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            stable <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync_q[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_LAST) begin
                    stable[i] <= sync_q[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Delayed copy of the accepted level for release (1 -> 0) detection.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            stable_d <= '0;
        end else begin
            stable_d <= stable;
        end
    end

    // Release pulse is high for the single cycle in which the accepted level has just dropped.
    always_comb begin
        release_p = stable_d & ~stable;
    end

    // Each release inverts that switch's toggle bit.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            toggle <= '0;
        end else begin
            toggle <= toggle ^ release_p;
        end
    end

`ifdef SWITCH_PRESS_COUNT_EN
    logic [1:0] press_count;

    // Modulo-4 release counter; simultaneous releases add two.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            press_count <= '0;
        end else begin
            press_count <= press_count + 2'(release_p[0]) + 2'(release_p[1]);
        end
    end

    assign o_LED_3 = press_count[0];
    assign o_LED_4 = press_count[1];
`else
    assign o_LED_3 = 1'b0;
    assign o_LED_4 = 1'b0;
`endif

    assign o_Debounced_1 = stable[0];
    assign o_Debounced_2 = stable[1];
    assign o_LED_1       = toggle[0] ^ toggle[1];
    assign o_LED_2       = ~(toggle[0] ^ toggle[1]);

endmodule

// File: tb/tb_switch_toggle_decoder.sv
// tb_switch_toggle_decoder
// Directed stimulus with a cycle-stamped scoreboard; a negedge monitor
// compares DUT outputs against entries due in the current cycle.
// Honours SWITCH_PRESS_COUNT_EN for the LED_3/LED_4 expectations.
module tb_switch_toggle_decoder;

    logic clk = 1'b0;
    logic rst;
    logic sw1;
    logic sw2;
    logic deb1, deb2, led1, led2, led3, led4;

    always #5 clk = ~clk;

    switch_toggle_decoder #(.DEBOUNCE_LIMIT(4)) dut (
        .i_Clk        (clk),
        .i_Reset      (rst),
        .i_Switch_1   (sw1),
        .i_Switch_2   (sw2),
        .o_Debounced_1(deb1),
        .o_Debounced_2(deb2),
        .o_LED_1      (led1),
        .o_LED_2      (led2),
        .o_LED_3      (led3),
        .o_LED_4      (led4)
    );

    typedef struct {
        int         cyc;
        string      name;
        logic [5:0] mask;
        logic [5:0] val;
    } exp_t;

    localparam logic [5:0] M_D1  = 6'b100000;
    localparam logic [5:0] M_D2  = 6'b010000;
    localparam logic [5:0] M_LED = 6'b001111;
    localparam logic [5:0] M_ALL = 6'b111111;

    exp_t sb[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    // reference model of the toggle bits and release count
    logic m_t1 = 1'b0;
    logic m_t2 = 1'b0;
    int   m_cnt = 0;

    always @(posedge clk) cyc++;

    // Monitor: compare every scoreboard entry due in this cycle.
    always @(negedge clk) begin
        logic [5:0] obs;
        obs = {deb1, deb2, led1, led2, led3, led4};
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                n_vec++;
                if ((obs & sb[i].mask) !== sb[i].val) begin
                    n_err++;
                    $display("FAIL %s cyc=%0d got=%b want=%b mask=%b {deb1,deb2,led1,led2,led3,led4}",
                             sb[i].name, cyc, obs & sb[i].mask, sb[i].val, sb[i].mask);
                end
                sb.delete(i);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_out(input int dly, input string nm, input logic [5:0] m, input logic [5:0] v);
        exp_t e;
        e.cyc  = cyc + dly;
        e.name = nm;
        e.mask = m;
        e.val  = v & m;
        sb.push_back(e);
    endtask

    function automatic logic [5:0] led_exp();
        logic [1:0] mc;
        logic       x;
`ifdef SWITCH_PRESS_COUNT_EN
        mc = 2'(m_cnt % 4);
`else
        mc = 2'b00;
`endif
        x = m_t1 ^ m_t2;
        return {2'b00, x, ~x, mc[0], mc[1]};
    endfunction

    initial begin
        rst = 1'b1;
        sw1 = 1'b0;
        sw2 = 1'b0;
        tick(3);
        expect_out(0, "reset_state", M_ALL, 6'b000100);
        n_vec++;
        if (led2 !== 1'b1) begin
            n_err++;
            $display("FAIL reset_led2 got=%b want=1", led2);
        end
        n_vec++;
        if (deb1 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_deb1 got=%b want=0", deb1);
        end
        tick(1);
        rst = 1'b0;
        tick(2);

        // single press/release of switch 1: accept latency is 6 cycles
        sw1 = 1'b1;
        expect_out(5, "deb1_rise_early", M_D1, 6'b000000);
        expect_out(6, "deb1_rise", M_D1, 6'b100000);
        tick(10);
        sw1 = 1'b0;
        m_t1 = ~m_t1;
        m_cnt += 1;
        expect_out(5, "deb1_fall_early", M_D1, 6'b100000);
        expect_out(6, "deb1_fall", M_D1, 6'b000000);
        expect_out(10, "led_release1", M_LED, led_exp());
        tick(10);

        // bounce 1,0,1,0 then 0: never accepted, no toggle
        sw1 = 1'b1; tick(1);
        sw1 = 1'b0; tick(1);
        sw1 = 1'b1; tick(1);
        sw1 = 1'b0;
        for (int k = 0; k <= 8; k++) expect_out(k, "bounce_deb1", M_D1, 6'b000000);
        expect_out(8, "bounce_led", M_LED, led_exp());
        tick(10);

        // simultaneous press and release of both switches
        sw1 = 1'b1;
        sw2 = 1'b1;
        expect_out(5, "dual_rise_early", M_D1 | M_D2, 6'b000000);
        expect_out(6, "dual_rise", M_D1 | M_D2, 6'b110000);
        tick(10);
        sw1 = 1'b0;
        sw2 = 1'b0;
        m_t1 = ~m_t1;
        m_t2 = ~m_t2;
        m_cnt += 2;
        expect_out(10, "led_dual_release", M_LED, led_exp());
        tick(10);

        // six single releases of switch 2 (count wraps through 0)
        for (int r = 0; r < 6; r++) begin
            sw2 = 1'b1;
            tick(8);
            sw2 = 1'b0;
            m_t2 = ~m_t2;
            m_cnt += 1;
            expect_out(9, "led_release2", M_LED, led_exp());
            tick(10);
        end

        // reset pulsed while switch 1 is held and accepted
        sw1 = 1'b1;
        expect_out(6, "deb1_held", M_D1, 6'b100000);
        tick(8);
        rst = 1'b1;
        expect_out(1, "reset_mid_hold", M_ALL, 6'b000100);
        tick(1);
        rst = 1'b0;
        m_t1 = 1'b0;
        m_t2 = 1'b0;
        m_cnt = 0;
        expect_out(5, "deb1_reacq_early", M_D1, 6'b000000);
        expect_out(6, "deb1_reacq", M_D1, 6'b100000);
        expect_out(11, "led_no_toggle_held", M_LED, led_exp());
        tick(12);
        sw1 = 1'b0;
        m_t1 = ~m_t1;
        m_cnt += 1;
        expect_out(10, "led_release_after_reset", M_LED, led_exp());
        tick(12);

        n_vec++;
        if (deb1 !== 1'b0) begin
            n_err++;
            $display("FAIL final_deb1 got=%b want=0", deb1);
        end

        // any expectation never reached counts as a miss
        foreach (sb[i]) begin
            n_vec++;
            n_err++;
            $display("FAIL %s never checked (due cyc=%0d, now %0d)", sb[i].name, sb[i].cyc, cyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        if (n_err != 0) $display("RESULT: FAIL");
        else $display("RESULT: PASS");
        $finish;
    end

endmodule
